// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port data RAM: round-robin with a burst cap,
// combinational grant, and read-valid returned one cycle after a granted read.
module ram_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [3:0] CAP = 4'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t     state, nstate;
   logic [3:0] cnt, ncnt;
   logic       lst, nlst;
   logic       win0, win1;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         lst   <= 1'b1;
      end else begin
         state <= nstate;
         cnt   <= ncnt;
         lst   <= nlst;
      end
   end

   // Winner selection, then the owner/counter update it implies.
   always_comb begin
      win0   = 1'b0;
      win1   = 1'b0;
      nstate = state;
      ncnt   = cnt;
      nlst   = lst;
      if (reset) begin
         case (state)
            IDLE: begin
               if (m0_req && m1_req) begin
                  win0 = lst;
                  win1 = ~lst;
               end else begin
                  win0 = m0_req;
                  win1 = m1_req;
               end
            end
            OWN0: begin
               if (m0_req) begin
                  if (m1_req && cnt == CAP) win1 = 1'b1;
                  else                      win0 = 1'b1;
               end else begin
                  win1 = m1_req;
               end
            end
            OWN1: begin
               if (m1_req) begin
                  if (m0_req && cnt == CAP) win0 = 1'b1;
                  else                      win1 = 1'b1;
               end else begin
                  win0 = m0_req;
               end
            end
            default: ;
         endcase
      end
      if (win0) begin
         if (state == OWN0) begin
            ncnt = (cnt != 4'hF) ? cnt + 4'd1 : cnt;
         end else begin
            nstate = OWN0;
            ncnt   = 4'd1;
            nlst   = 1'b0;
         end
      end else if (win1) begin
         if (state == OWN1) begin
            ncnt = (cnt != 4'hF) ? cnt + 4'd1 : cnt;
         end else begin
            nstate = OWN1;
            ncnt   = 4'd1;
            nlst   = 1'b1;
         end
      end else begin
         nstate = IDLE;
         ncnt   = 4'd0;
      end
   end

   always_comb begin
      m0_gnt    = win0;
      m1_gnt    = win1;
      ram_en    = win0 | win1;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (win0) begin
         ram_we    = m0_we;
         ram_addr  = m0_addr;
         ram_wdata = m0_wdata;
      end else if (win1) begin
         ram_we    = m1_we;
         ram_addr  = m1_addr;
         ram_wdata = m1_wdata;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
      end else begin
         m0_rvalid <= win0 & ~m0_we;
         m1_rvalid <= win1 & ~m1_we;
      end
   end

   // RAM read data is already aligned with rvalid; no extra register.
   assign m0_rdata = ram_rdata;
   assign m1_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed vector bench for ram_arbiter with a small synchronous RAM model.
module tb_ram_arbiter;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [7:0]  m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_en, ram_we;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;

   int nvec = 0;
   int nerr = 0;

   ram_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(4)) dut (
      .CLK(CLK), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 CLK = ~CLK;

   // RAM model: unwritten words read back as 0xA50000nn.
   logic [31:0]  mem [256];
   logic [255:0] wrv;
   logic [31:0]  rdq;
   always @(posedge CLK) begin
      if (!reset) wrv <= '0;
      else if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wrv[ram_addr] <= 1'b1;
         end else begin
            rdq <= wrv[ram_addr] ? mem[ram_addr] : {24'hA50000, ram_addr};
         end
      end
   end
   assign ram_rdata = rdq;

   typedef struct {
      logic        rst, r0, w0, r1, w1;
      logic [7:0]  a0, a1;
      logic [31:0] d0, d1;
      logic [45:0] exp;
      logic        ck;
      logic [31:0] rd;
   } vec_t;

   function automatic vec_t mkv(input logic rst, r0, w0, input logic [7:0] a0,
                                input logic [31:0] d0, input logic r1, w1,
                                input logic [7:0] a1, input logic [31:0] d1,
                                input logic g0, g1, en, we, input logic [7:0] ea,
                                input logic [31:0] ed, input logic rv0, rv1,
                                input logic ck, input logic [31:0] rd);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.exp = {g0, g1, en, we, ea, ed, rv0, rv1};
      v.ck = ck; v.rd = rd;
      return v;
   endfunction

   function automatic logic [45:0] obs();
      return {m0_gnt, m1_gnt, ram_en, ram_we, ram_addr, ram_wdata, m0_rvalid, m1_rvalid};
   endfunction

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   vec_t tv [23];

   initial begin
      // rst r0 w0 a0 d0 | r1 w1 a1 d1 || g0 g1 en we addr wdata rv0 rv1 || ck rdata
      tv[0]  = mkv(0,1,0,1,0, 1,0,2,0, 0,0,0,0,0,0, 0,0, 0,0);
      tv[1]  = mkv(0,1,0,1,0, 1,0,2,0, 0,0,0,0,0,0, 0,0, 0,0);
      tv[2]  = mkv(1,1,0,1,0, 1,0,2,0, 1,0,1,0,1,0, 0,0, 0,0);
      tv[3]  = mkv(1,1,0,1,0, 1,0,2,0, 1,0,1,0,1,0, 1,0, 1,32'hA5000001);
      tv[4]  = mkv(1,1,0,1,0, 1,0,2,0, 1,0,1,0,1,0, 1,0, 0,0);
      tv[5]  = mkv(1,1,0,1,0, 1,0,2,0, 1,0,1,0,1,0, 1,0, 0,0);
      tv[6]  = mkv(1,1,0,1,0, 1,0,2,0, 0,1,1,0,2,0, 1,0, 0,0);
      tv[7]  = mkv(1,1,0,1,0, 1,0,2,0, 0,1,1,0,2,0, 0,1, 1,32'hA5000002);
      tv[8]  = mkv(1,1,0,1,0, 1,0,2,0, 0,1,1,0,2,0, 0,1, 0,0);
      tv[9]  = mkv(1,1,0,1,0, 1,0,2,0, 0,1,1,0,2,0, 0,1, 0,0);
      tv[10] = mkv(1,1,0,1,0, 1,0,2,0, 1,0,1,0,1,0, 0,1, 0,0);
      tv[11] = mkv(1,1,0,1,0, 1,0,2,0, 1,0,1,0,1,0, 1,0, 0,0);
      tv[12] = mkv(1,1,0,1,0, 1,0,2,0, 1,0,1,0,1,0, 1,0, 0,0);
      tv[13] = mkv(1,1,0,1,0, 1,0,2,0, 1,0,1,0,1,0, 1,0, 0,0);
      tv[14] = mkv(1,1,1,3,32'hDEADBEEF, 0,0,0,0, 1,0,1,1,3,32'hDEADBEEF, 1,0, 0,0);
      tv[15] = mkv(1,1,0,3,0, 0,0,0,0, 1,0,1,0,3,0, 0,0, 0,0);
      tv[16] = mkv(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 1,0, 1,32'hDEADBEEF);
      tv[17] = mkv(1,1,0,1,0, 1,0,3,0, 0,1,1,0,3,0, 0,0, 0,0);
      tv[18] = mkv(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,1, 1,32'hDEADBEEF);
      tv[19] = mkv(1,1,0,3,0, 1,0,3,0, 1,0,1,0,3,0, 0,0, 0,0);
      tv[20] = mkv(1,1,0,3,0, 1,0,3,0, 1,0,1,0,3,0, 1,0, 0,0);
      tv[21] = mkv(1,0,0,3,0, 1,0,5,0, 0,1,1,0,5,0, 1,0, 0,0);
      tv[22] = mkv(1,1,0,3,0, 1,0,5,0, 0,1,1,0,5,0, 0,1, 1,32'hA5000005);

      for (int i = 0; i < 23; i++) begin
         @(negedge CLK);
         reset = tv[i].rst;
         m0_req = tv[i].r0; m0_we = tv[i].w0; m0_addr = tv[i].a0; m0_wdata = tv[i].d0;
         m1_req = tv[i].r1; m1_we = tv[i].w1; m1_addr = tv[i].a1; m1_wdata = tv[i].d1;
         #1;
         check($sformatf("vec%0d", i), 64'(obs()), 64'(tv[i].exp));
         if (tv[i].ck)
            check($sformatf("vec%0d_rdata", i), 64'(m0_rvalid ? m0_rdata : m1_rdata), 64'(tv[i].rd));
      end

      // Reset during a pending read: rvalid drops at once, access suppressed.
      @(negedge CLK);
      m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 8'd5; m1_wdata = '0;
      #1 check("midrst_gnt", {m1_gnt, ram_en, ram_addr}, {1'b1, 1'b1, 8'd5});
      @(posedge CLK);
      #1 check("midrst_rv_pre", {m0_rvalid, m1_rvalid}, 2'b01);
      reset = 0;
      #1 check("midrst_clr", {m0_rvalid, m1_rvalid, m1_gnt, ram_en}, 4'b0000);
      @(posedge CLK);
      #1 check("midrst_hold", {m0_rvalid, m1_rvalid, m1_gnt, ram_en}, 4'b0000);
      @(negedge CLK);
      reset = 1; m0_req = 1; m0_we = 0; m0_addr = 8'd7;
      #1 check("midrst_idle", {m0_gnt, m1_gnt, ram_addr}, {1'b1, 1'b0, 8'd7});
      @(posedge CLK);
      #1 check("midrst_rv_post", {m0_rvalid, m1_rvalid, m0_rdata}, {2'b10, 32'hA5000007});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: m0 (CPU load/store path) and m1 (debug/DMA loader port).
- Grants one access per cycle using round-robin with a burst cap, drives the RAM port, and routes synchronous read data back to the granted requester one cycle later.
- Sits between the core and the RAM instance in the selevy top level.

Parameters:
- ADDR_W, 8, RAM word-address width.
- DATA_W, 32, data word width.
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting (1..15).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  m0 access request.
- m0_we  in  1  m0 write enable (1 = write, 0 = read).
- m0_addr  in  ADDR_W  m0 word address.
- m0_wdata  in  DATA_W  m0 write data.
- m0_gnt  out  1  m0 access accepted this cycle.
- m0_rvalid  out  1  m0 read data valid.
- m0_rdata  out  DATA_W  m0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same widths and meanings as the m0 ports, for m1.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid the cycle after ram_en=1 with ram_we=0.

Behaviour:
- State: FSM {IDLE, OWN0, OWN1}, plus a burst counter cnt (4 bits), last-winner pointer lst, and registered read-return flags.
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, lst=1 so m0 wins the first tie.
  - m0_rvalid=m1_rvalid=0.
- Grant is combinational from the current state and the req inputs; at most one gnt is high.
  - ram_en = m0_gnt|m1_gnt.
  - ram_we/ram_addr/ram_wdata are muxed from the granted master; they are 0 when no grant is given.
  - While reset=0, all gnt and ram_en are 0.
- Winner selection each cycle:
  - IDLE: a single requester wins. If both request, the master != lst wins.
  - OWNx with req_x=1: x wins unless the other master requests and cnt==MAX_BURST; in that case the other master wins.
  - OWNx with req_x=0: the other master wins if it requests, else no grant.
- Edge update:
  - Winner w with w==current owner: cnt=min(cnt+1,15).
  - Winner w is a new owner: state=OWNw, cnt=1, lst=w.
  - No winner: state=IDLE, cnt=0 (lst is kept).
- Read return:
  - mX_rvalid = registered (mX_gnt & ~mX_we). It is high exactly one cycle after the granted read and low after a write.
  - m0_rdata = m1_rdata = ram_rdata, unregistered; meaningful only while rvalid is high.
- Requesters hold req/addr/we/wdata stable until they see gnt high. Dropping req before gnt is legal, and no access occurs.
- Back-to-back reads by the same master: rvalid stays high on consecutive cycles, each beat carrying the data of the previous cycle's address.
- Reset asserted mid-operation: pending rvalid is cleared immediately and the RAM access of that cycle is suppressed.
- MAX_BURST=1: strict alternation whenever both masters request.

Test Plan:
- Reset: hold reset=0 with m0_req=m1_req=1 -> all gnt, rvalid and ram_en = 0. Release reset with both requesting -> m0_gnt=1 on the first cycle.
- Single master: m0 writes 0xDEADBEEF to addr 3, then reads addr 3 -> the read cycle has m0_gnt=1, ram_we=0, ram_addr=3; the next cycle has m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Burst cap: MAX_BURST=4, m0 and m1 request continuously from reset release -> grant pattern is m0 x4, m1 x4, m0 x4, with exactly one gnt per cycle.
- Owner release: m0 owns with cnt=2 and drops req while m1 requests -> m1_gnt=1 the same cycle, and state becomes OWN1 on the next edge.
- Idle tie: m1 was the last winner, both masters idle one cycle, then both request -> m0 wins. Repeat with m0 as the last winner -> m1 wins.
- Mid-read reset: m1 read granted at addr 5, reset pulsed low before the next edge -> m1_rvalid stays 0 and the FSM is IDLE after release.
